// File: rtl/led_fade_pwm_if.sv
// Pattern-in / LED-drive bundle between the chaser pattern generator and the
// LED fader. The master side supplies the target pattern and observes the drive outputs.
interface led_fade_pwm_if;
    logic [7:0] PAT_IN;
    logic [7:0] LED_OUT;
    logic       TICK;
    logic       SETTLED;

    modport master (output PAT_IN, input LED_OUT, TICK, SETTLED);
    modport slave  (input PAT_IN, output LED_OUT, TICK, SETTLED);
endinterface

// File: rtl/led_fade_pwm.sv
// Eight-channel LED fader: each level ramps toward its pattern bit once per fade tick; PWM drives the pins.
// Define LED_GAMMA_EN for a squared (gamma-corrected) duty curve; the default build uses linear duty.
module led_fade_pwm #(
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 65536,
    parameter int STEP     = 16
) (
    input  logic           CLK,
    input  logic           RST,
    led_fade_pwm_if.slave  bus
);
    localparam int FW = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] STEP_L    = PWM_BITS'(STEP);
    localparam logic [FW-1:0]       FADE_LAST = FW'(FADE_DIV - 1);

    logic [7:0]          pat_q, pat_d;
    logic [7:0]          led_q, led_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FW-1:0]       fade_cnt_q, fade_cnt_d;
    logic [PWM_BITS-1:0] level_q [8];
    logic [PWM_BITS-1:0] level_d [8];
    logic [PWM_BITS-1:0] duty [8];
    logic [7:0]          at_target;
    logic                tick;

    assign tick = (fade_cnt_q == FADE_LAST);

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_chan
`ifdef LED_GAMMA_EN
        // Full-width square so no low bits are lost before the shift.
        logic [2*PWM_BITS-1:0] sq;
        assign sq       = {{PWM_BITS{1'b0}}, level_q[gi]} * {{PWM_BITS{1'b0}}, level_q[gi]};
        assign duty[gi] = sq[2*PWM_BITS-1:PWM_BITS];
`else
        assign duty[gi] = level_q[gi];
`endif
        assign at_target[gi] = (level_q[gi] == (pat_q[gi] ? MAX : {PWM_BITS{1'b0}}));
    end

    always_comb begin
        pat_d      = bus.PAT_IN;
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
        fade_cnt_d = tick ? '0 : fade_cnt_q + FW'(1);
        led_d      = '0;
        for (int i = 0; i < 8; i++) begin
            level_d[i] = level_q[i];
            if (tick) begin
                // Compare headroom first so the ramp saturates instead of wrapping.
                if (pat_q[i])
                    level_d[i] = (MAX - level_q[i] > STEP_L) ? level_q[i] + STEP_L : MAX;
                else
                    level_d[i] = (level_q[i] > STEP_L) ? level_q[i] - STEP_L : '0;
            end
            if (level_q[i] == MAX)
                led_d[i] = 1'b1;
            else if (level_q[i] != '0)
                led_d[i] = (duty[i] > pwm_cnt_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pat_q      <= '0;
            led_q      <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            for (int i = 0; i < 8; i++) level_q[i] <= '0;
        end else begin
            pat_q      <= pat_d;
            led_q      <= led_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            for (int i = 0; i < 8; i++) level_q[i] <= level_d[i];
        end
    end

    assign bus.LED_OUT = led_q;
    assign bus.TICK    = tick;
    assign bus.SETTLED = &at_target;
endmodule
